// File: rtl/instr_fetch_queue.sv
// ---------------------------------------------------------------------------
// instr_fetch_queue
//   Small first-word-fall-through queue that decouples instruction fetch from
//   decode. Each entry holds {pc, instr}. A branch/jump redirect (flush)
//   empties the queue in one cycle. A push attempted while full is dropped
//   and latches a sticky overflow flag.
//
// Ports
//   clk           : single clock, all state updates on its rising edge
//   rst           : asynchronous, active-high reset
//   fq_wr_en      : fetch pushes {fq_pc_in, fq_instr_in} this cycle
//   fq_pc_in      : PC of the fetched instruction
//   fq_instr_in   : instruction word fetched at fq_pc_in
//   fq_rd_en      : decode consumes the head entry this cycle
//   flush         : redirect, discard all queued entries
//   fq_full       : queue holds DEPTH entries, fetch must stall
//   fq_valid      : head entry present
//   fq_pc_out     : PC of the head entry (0 when empty)
//   fq_instr_out  : instruction of the head entry (NOP 0 when empty)
//   fq_count      : occupied entries, 0..DEPTH
//   fq_ovf        : sticky, set when a push was attempted while full
// ---------------------------------------------------------------------------
module instr_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fq_wr_en,
  input  logic [31:0]   fq_pc_in,
  input  logic [31:0]   fq_instr_in,
  input  logic          fq_rd_en,
  input  logic          flush,
  output logic          fq_full,
  output logic          fq_valid,
  output logic [31:0]   fq_pc_out,
  output logic [31:0]   fq_instr_out,
  output logic [AW:0]   fq_count,
  output logic          fq_ovf
);

  // Storage: {pc, instr} per entry; contents are never reset.
  logic [63:0]   mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          ovf_r;

  logic          full_s;
  logic          valid_s;
  logic          push_s;
  logic          pop_s;
  logic          ovf_set_s;
  logic [63:0]   head_s;

  // Status is decoded from registered occupancy only, so it never depends
  // on the same-cycle request inputs.
  assign full_s  = (count_r == (AW+1)'(DEPTH));
  assign valid_s = (count_r != {(AW+1){1'b0}});

  // Request qualification: flush overrides both directions.
  always_comb begin
    push_s    = 1'b0;
    pop_s     = 1'b0;
    ovf_set_s = 1'b0;
    if (flush) begin
      push_s    = 1'b0;
      pop_s     = 1'b0;
      ovf_set_s = 1'b0;
    end else begin
      push_s    = fq_wr_en & ~full_s;
      pop_s     = fq_rd_en & valid_s;
      ovf_set_s = fq_wr_en & full_s;
    end
  end

  // Entry write on an accepted push.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {fq_pc_in, fq_instr_in};
    end
  end

  // Pointers, occupancy and sticky overflow; pointers wrap naturally since
  // DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
      ovf_r    <= 1'b0;
    end else begin
      if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end
      if (flush) begin
        wr_ptr_r <= {AW{1'b0}};
        rd_ptr_r <= {AW{1'b0}};
        count_r  <= {(AW+1){1'b0}};
      end else begin
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + AW'(1);
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + AW'(1);
        end
        case ({push_s, pop_s})
          2'b10:   count_r <= count_r + (AW+1)'(1);
          2'b01:   count_r <= count_r - (AW+1)'(1);
          default: count_r <= count_r;
        endcase
      end
    end
  end

  // Fall-through head read; empty queue presents PC 0 and a NOP.
  always_comb begin
    head_s = mem_r[rd_ptr_r];
    if (valid_s) begin
      fq_pc_out    = head_s[63:32];
      fq_instr_out = head_s[31:0];
    end else begin
      fq_pc_out    = 32'h0000_0000;
      fq_instr_out = 32'h0000_0000;
    end
  end

  assign fq_full  = full_s;
  assign fq_valid = valid_s;
  assign fq_count = count_r;
  assign fq_ovf   = ovf_r;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_queue
//   Directed bench for instr_fetch_queue (DEPTH=4). Inputs are driven 1 ns
//   after the rising edge and outputs sampled there, away from the edge.
// ---------------------------------------------------------------------------
module tb_instr_fetch_queue;

  logic        clk;
  logic        rst;
  logic        fq_wr_en;
  logic [31:0] fq_pc_in;
  logic [31:0] fq_instr_in;
  logic        fq_rd_en;
  logic        flush;
  logic        fq_full;
  logic        fq_valid;
  logic [31:0] fq_pc_out;
  logic [31:0] fq_instr_out;
  logic [2:0]  fq_count;
  logic        fq_ovf;

  int n_checks;
  int n_errors;

  instr_fetch_queue #(.DEPTH(4), .AW(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .fq_wr_en     (fq_wr_en),
    .fq_pc_in     (fq_pc_in),
    .fq_instr_in  (fq_instr_in),
    .fq_rd_en     (fq_rd_en),
    .flush        (flush),
    .fq_full      (fq_full),
    .fq_valid     (fq_valid),
    .fq_pc_out    (fq_pc_out),
    .fq_instr_out (fq_instr_out),
    .fq_count     (fq_count),
    .fq_ovf       (fq_ovf)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock cycle with the given request, then return to idle inputs.
  task automatic cyc(input logic wr, input logic [31:0] pc, input logic [31:0] ins,
                     input logic rd, input logic fl);
    fq_wr_en    = wr;
    fq_pc_in    = pc;
    fq_instr_in = ins;
    fq_rd_en    = rd;
    flush       = fl;
    @(posedge clk);
    #1;
    fq_wr_en = 1'b0;
    fq_rd_en = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc, input logic [31:0] ins);
    check_val({tag, "_pc"}, fq_pc_out, pc);
    check_val({tag, "_instr"}, fq_instr_out, ins);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst         = 1'b1;
    fq_wr_en    = 1'b0;
    fq_pc_in    = 32'h0;
    fq_instr_in = 32'h0;
    fq_rd_en    = 1'b0;
    flush       = 1'b0;

    // Reset state
    #12;
    check_val("rst_valid", {31'b0, fq_valid}, 32'd0);
    check_val("rst_full",  {31'b0, fq_full},  32'd0);
    check_val("rst_count", {29'b0, fq_count}, 32'd0);
    check_val("rst_ovf",   {31'b0, fq_ovf},   32'd0);
    check_head("rst_head", 32'h0, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Empty corner: pop on empty, then push+pop on empty
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check_val("empty_pop_count", {29'b0, fq_count}, 32'd0);
    check_val("empty_pop_ovf",   {31'b0, fq_ovf},   32'd0);
    cyc(1'b1, 32'h0040_0020, 32'h2008_0020, 1'b1, 1'b0);
    check_val("empty_pp_count", {29'b0, fq_count}, 32'd1);
    check_head("empty_pp_head", 32'h0040_0020, 32'h2008_0020);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check_val("empty_pp_drain", {29'b0, fq_count}, 32'd0);

    // Fill (pointers start at 1, so this wraps)
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 32'h0040_0000 + 32'(4*i), 32'h2008_0001 + 32'(i), 1'b0, 1'b0);
      check_val("fill_count", {29'b0, fq_count}, 32'(i+1));
    end
    check_val("fill_full", {31'b0, fq_full}, 32'd1);
    check_head("fill_head", 32'h0040_0000, 32'h2008_0001);

    // Overflow
    cyc(1'b1, 32'h0040_0010, 32'h2008_0005, 1'b0, 1'b0);
    check_val("ovf_flag",  {31'b0, fq_ovf},   32'd1);
    check_val("ovf_count", {29'b0, fq_count}, 32'd4);
    check_head("ovf_head", 32'h0040_0000, 32'h2008_0001);

    // Drain in order
    for (int i = 0; i < 4; i++) begin
      check_head("drain_head", 32'h0040_0000 + 32'(4*i), 32'h2008_0001 + 32'(i));
      cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    end
    check_val("drain_valid", {31'b0, fq_valid}, 32'd0);
    check_head("drain_nop", 32'h0, 32'h0);

    // Refill and flush; overflow flag must survive
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 32'h0040_0000 + 32'(4*i), 32'h2008_0001 + 32'(i), 1'b0, 1'b0);
    end
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    check_val("flush_count", {29'b0, fq_count}, 32'd0);
    check_val("flush_valid", {31'b0, fq_valid}, 32'd0);
    check_val("flush_ovf",   {31'b0, fq_ovf},   32'd1);

    // Simultaneous push+pop at count 2 for 6 cycles
    for (int k = 0; k < 2; k++) begin
      cyc(1'b1, 32'h0040_0200 + 32'(4*k), 32'h3000_0000 + 32'(k), 1'b0, 1'b0);
    end
    for (int i = 0; i < 6; i++) begin
      check_head("sim_head", 32'h0040_0200 + 32'(4*i), 32'h3000_0000 + 32'(i));
      cyc(1'b1, 32'h0040_0200 + 32'(4*(i+2)), 32'h3000_0000 + 32'(i+2), 1'b1, 1'b0);
      check_val("sim_count", {29'b0, fq_count}, 32'd2);
    end
    for (int i = 6; i < 8; i++) begin
      check_head("sim_tail", 32'h0040_0200 + 32'(4*i), 32'h3000_0000 + 32'(i));
      cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    end
    check_val("sim_empty", {31'b0, fq_valid}, 32'd0);

    // Flush priority over push and pop
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 32'h0040_0400 + 32'(4*k), 32'h3400_0000 + 32'(k), 1'b0, 1'b0);
    end
    check_val("fp_pre_count", {29'b0, fq_count}, 32'd3);
    cyc(1'b1, 32'h0040_040C, 32'h3400_0003, 1'b1, 1'b1);
    check_val("fp_count", {29'b0, fq_count}, 32'd0);
    check_val("fp_valid", {31'b0, fq_valid}, 32'd0);
    cyc(1'b1, 32'h0040_0100, 32'h2008_0100, 1'b0, 1'b0);
    check_head("fp_next_head", 32'h0040_0100, 32'h2008_0100);
    check_val("fp_next_count", {29'b0, fq_count}, 32'd1);

    // Asynchronous reset between edges with count 3
    cyc(1'b1, 32'h0040_0104, 32'h2008_0104, 1'b0, 1'b0);
    cyc(1'b1, 32'h0040_0108, 32'h2008_0108, 1'b0, 1'b0);
    check_val("ar_pre_count", {29'b0, fq_count}, 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check_val("ar_valid", {31'b0, fq_valid}, 32'd0);
    check_val("ar_count", {29'b0, fq_count}, 32'd0);
    check_val("ar_ovf",   {31'b0, fq_ovf},   32'd0);
    check_head("ar_head", 32'h0, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1'b1, 32'h0040_0300, 32'h2008_0300, 1'b0, 1'b0);
    check_head("ar_first", 32'h0040_0300, 32'h2008_0300);

    // Push+pop while full: pop wins, push rejected, overflow set
    for (int k = 1; k < 4; k++) begin
      cyc(1'b1, 32'h0040_0300 + 32'(4*k), 32'h2008_0300 + 32'(4*k), 1'b0, 1'b0);
    end
    check_val("fpp_full", {31'b0, fq_full}, 32'd1);
    cyc(1'b1, 32'h0040_0310, 32'h2008_0310, 1'b1, 1'b0);
    check_val("fpp_count", {29'b0, fq_count}, 32'd3);
    check_val("fpp_ovf",   {31'b0, fq_ovf},   32'd1);
    for (int k = 1; k < 4; k++) begin
      check_head("fpp_drain", 32'h0040_0300 + 32'(4*k), 32'h2008_0300 + 32'(4*k));
      cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    end
    check_val("fpp_empty", {31'b0, fq_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, the number of queue entries (power of two, 2..16).
REQ-002 The module SHALL have parameter AW, default 2, the pointer width (log2 DEPTH).
REQ-003 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port fq_wr_en  input  1  fetch pushes {fq_pc_in, fq_instr_in} this cycle.
REQ-006 Port fq_pc_in  input  32  PC of the fetched instruction (the PC register output).
REQ-007 Port fq_instr_in  input  32  instruction word read from instruction memory at fq_pc_in.
REQ-008 Port fq_rd_en  input  1  decode consumes the head entry this cycle.
REQ-009 Port flush  input  1  branch/jump redirect; discard all queued entries.
REQ-010 Port fq_full  output  1  queue holds DEPTH entries; fetch must stall its PC.
REQ-011 Port fq_valid  output  1  head entry present (queue not empty).
REQ-012 Port fq_pc_out  output  32  PC of the head entry.
REQ-013 Port fq_instr_out  output  32  instruction word of the head entry.
REQ-014 Port fq_count  output  AW+1  number of occupied entries, 0..DEPTH.
REQ-015 Port fq_ovf  output  1  sticky error: a push was attempted while full.

Function
REQ-016 Storage SHALL be a circular buffer of DEPTH entries of {pc[31:0], instr[31:0]} with write pointer, read pointer (AW bits each) and an occupancy counter (AW+1 bits).
REQ-017 A push SHALL be accepted only when fq_wr_en=1, fq_full=0 and flush=0; the entry is written at wr_ptr, wr_ptr increments modulo DEPTH.
REQ-018 A pop SHALL be accepted only when fq_rd_en=1, fq_valid=1 and flush=0; rd_ptr increments modulo DEPTH.
REQ-019 Counter update: +1 on push only, -1 on pop only, unchanged on simultaneous accepted push and pop.
REQ-020 fq_full SHALL be (count==DEPTH) and fq_valid SHALL be (count!=0), both decoded from registered state only.
REQ-021 The queue SHALL be first-word-fall-through: fq_pc_out/fq_instr_out show the entry at rd_ptr combinationally from storage, with no extra read latency.
REQ-022 Write-to-read latency SHALL be one cycle: an entry pushed at edge N is visible with fq_valid=1 in the cycle after edge N.
REQ-023 When fq_valid=0, fq_instr_out SHALL be 32'h00000000 (MIPS NOP) and fq_pc_out SHALL be 32'h00000000.
REQ-024 Push while full (fq_wr_en=1, fq_full=1, flush=0) SHALL be dropped, leave storage and pointers unchanged, and set fq_ovf=1.
REQ-025 Pop while empty SHALL be ignored with no state change and no error.
REQ-026 Push and pop in the same cycle while empty: push accepted, pop ignored, count becomes 1.
REQ-027 Push and pop in the same cycle while full: pop accepted, push rejected (fq_full is registered), fq_ovf set, count becomes DEPTH-1.
REQ-028 flush=1 SHALL, at the next edge, set wr_ptr=rd_ptr=0 and count=0, overriding any push or pop in the same cycle; storage contents need not be cleared.
REQ-029 flush SHALL NOT clear fq_ovf.
REQ-030 Pointer wrap from DEPTH-1 to 0 SHALL preserve FIFO order without loss or duplication.

Reset
REQ-031 Asserting rst SHALL immediately (without a clock edge) set wr_ptr=0, rd_ptr=0, count=0, fq_ovf=0, giving fq_full=0, fq_valid=0, fq_count=0, fq_pc_out=0, fq_instr_out=0.
REQ-032 Reset mid-operation SHALL discard all entries; the first push after rst deasserts SHALL appear as the head.
REQ-033 Storage array contents need not be reset.

Verification
REQ-034 Fill/drain: after reset, push PCs 0x00400000,0x04,0x08,0x0C with instrs 0x20080001..0x20080004 -> fq_full=1, count=4; pop four times -> same order out, fq_valid=0, fq_instr_out=0.
REQ-035 Overflow: with queue full, push pc 0x00400010 -> dropped, fq_ovf=1, count=4, head still 0x00400000; flush -> count=0, fq_ovf stays 1.
REQ-036 Simultaneous: count=2, push+pop in one cycle for 6 cycles -> count stays 2, pointers wrap, outputs follow push order exactly.
REQ-037 Flush priority: count=3 with fq_wr_en=1, fq_rd_en=1, flush=1 -> next cycle count=0, fq_valid=0; next push pc 0x00400100 appears as head.
REQ-038 Async reset: assert rst between clock edges with count=3 -> fq_valid=0, fq_count=0 before the next rising clk.
REQ-039 Empty corner: pop on empty -> no change; push+pop on empty with pc 0x00400020 -> count=1, head pc 0x00400020.
